// File: rtl/tdpram_pkg.sv
// Shared types and helpers for the TDPRAM port responder.
// Latency: n/a (types and combinational helpers only).
// Backpressure: n/a.
package tdpram_pkg;

    typedef enum logic [0:0] {
        WM_READ_FIRST  = 1'b0,
        WM_WRITE_FIRST = 1'b1
    } write_mode_t;

    localparam int COUNT_WIDTH = 32;

    // One byte lane of a strobed write: the new byte wins only where its strobe is set.
    function automatic logic [7:0] strobe_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       we_bit
    );
        return we_bit ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/tdpram_read_pipe.sv
// Valid/data register chain that turns an accepted access result into dout.
// Latency: READ_LATENCY (1 or 2) clk edges from acceptance to dout.
// Backpressure: none; one result per cycle, dout holds when nothing valid arrives.
module tdpram_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic [DATA_WIDTH-1:0] dout
);

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;

    generate
        if (READ_LATENCY == 2) begin : g_stage1
            logic                  s1_vld;
            logic [DATA_WIDTH-1:0] s1_dat;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                end else begin
                    s1_vld <= in_vld;
                    if (in_vld) begin
                        s1_dat <= in_dat;
                    end
                end
            end

            assign out_vld = s1_vld;
            assign out_dat = s1_dat;
        end else begin : g_direct
            assign out_vld = in_vld;
            assign out_dat = in_dat;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout <= '0;
        end else if (out_vld) begin
            dout <= out_dat;
        end
    end

endmodule

// File: rtl/tdpram_port_responder.sv
// Slave endpoint for a TDPRAM port: behavioural array, access counters, out-of-range flag.
// Latency: READ_LATENCY edges to dout; counters and oor_err update on the accepting edge.
// Backpressure: none; fully pipelined, one access per cycle.
module tdpram_port_responder
    import tdpram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 2 ** ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic                    cnt_clr,
    output logic [COUNT_WIDTH-1:0]  rd_count,
    output logic [COUNT_WIDTH-1:0]  wr_count,
    output logic                    oor_err
);

    localparam int                    NUM_LANES  = DATA_WIDTH / 8;
    localparam int                    IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0]   WORD_LIMIT = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam write_mode_t           MODE       = (WRITE_MODE == 1) ? WM_WRITE_FIRST : WM_READ_FIRST;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "tdpram_port_responder: READ_LATENCY must be 1 or 2");
        end
        if (WRITE_MODE != 0 && WRITE_MODE != 1) begin : g_bad_mode
            $fatal(1, "tdpram_port_responder: WRITE_MODE must be 0 or 1");
        end
        if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
            $fatal(1, "tdpram_port_responder: DATA_WIDTH must be a positive multiple of 8");
        end
        if (NUM_WORDS < 1 || 64'(NUM_WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
            $fatal(1, "tdpram_port_responder: NUM_WORDS must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  in_range;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  oor_hit;
    logic [IDX_WIDTH-1:0]  word_idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] result_word;

    logic [COUNT_WIDTH-1:0] rd_cnt_q;
    logic [COUNT_WIDTH-1:0] wr_cnt_q;
    logic                   oor_q;

    assign word_idx = addr[IDX_WIDTH-1:0];
    assign in_range = {1'b0, addr} < WORD_LIMIT;
    assign wr_acc   = en && (we != '0);
    assign rd_acc   = en && (we == '0);
    assign oor_hit  = en && !in_range;

    // Nonexistent words read as zero, so old_word is already safe for out-of-range reads.
    assign old_word = in_range ? mem[word_idx] : '0;

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            merged_word[8*i +: 8] = strobe_merge(old_word[8*i +: 8], din[8*i +: 8], we[i]);
        end
    end

    always_comb begin
        result_word = '0;
        if (in_range) begin
            result_word = (MODE == WM_WRITE_FIRST) ? merged_word : old_word;
        end
    end

    // Array contents survive reset; only in-range writes commit.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            mem[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            oor_q    <= 1'b0;
        end else if (cnt_clr) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            oor_q    <= 1'b0;
        end else begin
            if (rd_acc && (rd_cnt_q != CNT_MAX)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (wr_acc && (wr_cnt_q != CNT_MAX)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (oor_hit) begin
                oor_q <= 1'b1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
    assign oor_err  = oor_q;

    tdpram_read_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk    (clk),
        .resetn (resetn),
        .in_vld (en),
        .in_dat (result_word),
        .dout   (dout)
    );

endmodule

// File: tb/tb_tdpram_port_responder.sv
// Bench for tdpram_port_responder: three configurations share one stimulus stream.
// a: latency 1 read_first, b: latency 1 write_first, c: latency 2 read_first; all 1000 words.
module tb_tdpram_port_responder;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NW = 1000;

    logic          clk;
    logic          resetn;
    logic          en;
    logic          cnt_clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [3:0]    we;

    logic [DW-1:0] dout_a, dout_b, dout_c;
    logic [31:0]   rdc_a, wrc_a, rdc_b, wrc_b, rdc_c, wrc_c;
    logic          oor_a, oor_b, oor_c;

    int n_cmp = 0;
    int n_bad = 0;

    tdpram_port_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
                            .READ_LATENCY(1), .WRITE_MODE(0)) u_a (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .dout(dout_a), .en(en), .we(we),
        .cnt_clr(cnt_clr), .rd_count(rdc_a), .wr_count(wrc_a), .oor_err(oor_a));

    tdpram_port_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
                            .READ_LATENCY(1), .WRITE_MODE(1)) u_b (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .dout(dout_b), .en(en), .we(we),
        .cnt_clr(cnt_clr), .rd_count(rdc_b), .wr_count(wrc_b), .oor_err(oor_b));

    tdpram_port_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
                            .READ_LATENCY(2), .WRITE_MODE(0)) u_c (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .dout(dout_c), .en(en), .we(we),
        .cnt_clr(cnt_clr), .rd_count(rdc_c), .wr_count(wrc_c), .oor_err(oor_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word store over the full address space, plus a per-edge history of
    // access results so each configuration's dout is the result from its latency ago.
    logic [DW-1:0] m_mem [4096];
    int            cyc;
    logic          h_vld [16];
    logic [DW-1:0] h_rf  [16];
    logic [31:0]   m_rd, m_wr;
    logic          m_oor;
    logic [DW-1:0] e_a, e_b, e_c;

    task automatic model_reset();
        e_a = '0; e_b = '0; e_c = '0;
        m_rd = '0; m_wr = '0; m_oor = 1'b0;
        for (int i = 0; i < 16; i++) h_vld[i] = 1'b0;
    endtask

    task automatic model_edge();
        logic          oorq;
        logic [DW-1:0] old_w, mrg, r_wf;
        int            slot, prev;
        cyc++;
        if (!resetn) begin
            model_reset();
            return;
        end
        oorq  = int'(addr) >= NW;
        old_w = oorq ? '0 : m_mem[addr];
        mrg   = old_w;
        for (int i = 0; i < 4; i++) if (we[i]) mrg[8*i +: 8] = din[8*i +: 8];
        r_wf = oorq ? '0 : mrg;
        slot = cyc % 16;
        prev = (cyc + 15) % 16;
        h_vld[slot] = en;
        h_rf[slot]  = old_w;
        if (en) begin
            e_a = old_w;
            e_b = r_wf;
        end
        if (h_vld[prev]) e_c = h_rf[prev];
        if (en && we != 4'h0 && !oorq) m_mem[addr] = mrg;
        if (cnt_clr) begin
            m_rd = '0; m_wr = '0; m_oor = 1'b0;
        end else begin
            if (en && we == 4'h0 && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
            if (en && we != 4'h0 && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
            if (en && oorq) m_oor = 1'b1;
        end
    endtask

    task automatic step(input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] w, input logic c);
        en = e; addr = a; din = d; we = w; cnt_clr = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        repeat (3) step(1'b0, '0, '0, 4'h0, 1'b0);
        resetn = 1'b1;
        repeat (10) step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_a !== 32'h0) begin n_bad++; $display("FAIL reset_dout_a got %h want 0", dout_a); end
        n_cmp++; if (dout_b !== 32'h0) begin n_bad++; $display("FAIL reset_dout_b got %h want 0", dout_b); end
        n_cmp++; if (dout_c !== 32'h0) begin n_bad++; $display("FAIL reset_dout_c got %h want 0", dout_c); end
        n_cmp++; if (rdc_a !== 32'h0 || wrc_a !== 32'h0) begin
            n_bad++; $display("FAIL reset_counts got rd=%h wr=%h want 0/0", rdc_a, wrc_a);
        end
        n_cmp++; if (oor_a !== 1'b0) begin n_bad++; $display("FAIL reset_oor got %b want 0", oor_a); end
    endtask

    task automatic test_byte_strobes();
        step(1'b1, 12'd5, 32'hAABB_CCDD, 4'hF, 1'b0);
        step(1'b1, 12'd5, 32'h1122_3344, 4'b0101, 1'b0);
        step(1'b1, 12'd5, 32'h0, 4'h0, 1'b0);
        n_cmp++; if (dout_a !== 32'hAA22_CC44) begin n_bad++; $display("FAIL strobe_dout_a got %h want AA22CC44", dout_a); end
        n_cmp++; if (dout_b !== 32'hAA22_CC44) begin n_bad++; $display("FAIL strobe_dout_b got %h want AA22CC44", dout_b); end
        n_cmp++; if (wrc_a !== 32'd2) begin n_bad++; $display("FAIL strobe_wr_count got %0d want 2", wrc_a); end
        n_cmp++; if (rdc_a !== 32'd1) begin n_bad++; $display("FAIL strobe_rd_count got %0d want 1", rdc_a); end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'hAA22_CC44) begin n_bad++; $display("FAIL strobe_dout_c got %h want AA22CC44", dout_c); end
    endtask

    task automatic test_write_modes();
        step(1'b1, 12'd7, 32'h0000_00FF, 4'hF, 1'b0);
        step(1'b1, 12'd7, 32'h1234_5678, 4'hF, 1'b0);
        n_cmp++; if (dout_a !== 32'h0000_00FF) begin n_bad++; $display("FAIL read_first got %h want 000000FF", dout_a); end
        n_cmp++; if (dout_b !== 32'h1234_5678) begin n_bad++; $display("FAIL write_first got %h want 12345678", dout_b); end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'h0000_00FF) begin n_bad++; $display("FAIL read_first_lat2 got %h want 000000FF", dout_c); end
        n_cmp++; if (dout_a !== 32'h0000_00FF) begin n_bad++; $display("FAIL idle_hold_a got %h want 000000FF", dout_a); end
    endtask

    task automatic test_latency2_stream();
        for (int i = 0; i < 8; i++) step(1'b1, AW'(i), DW'(i), 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(i), '0, 4'h0, 1'b0);
            n_cmp++; if (dout_a !== DW'(i)) begin n_bad++; $display("FAIL stream_a[%0d] got %h want %h", i, dout_a, DW'(i)); end
            if (i > 0) begin
                n_cmp++; if (dout_c !== DW'(i - 1)) begin n_bad++; $display("FAIL stream_c[%0d] got %h want %h", i, dout_c, DW'(i - 1)); end
            end
        end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'd7) begin n_bad++; $display("FAIL stream_c_last got %h want 7", dout_c); end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'd7) begin n_bad++; $display("FAIL stream_c_hold got %h want 7", dout_c); end
    endtask

    task automatic test_out_of_range();
        step(1'b1, 12'd999, 32'hCAFE_F00D, 4'hF, 1'b0);
        step(1'b0, '0, '0, 4'h0, 1'b1);
        step(1'b1, 12'd1000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        n_cmp++; if (oor_a !== 1'b1) begin n_bad++; $display("FAIL oor_set got %b want 1", oor_a); end
        n_cmp++; if (wrc_a !== 32'd1) begin n_bad++; $display("FAIL oor_wr_counted got %0d want 1", wrc_a); end
        step(1'b1, 12'd1000, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_a !== 32'h0) begin n_bad++; $display("FAIL oor_read_a got %h want 0", dout_a); end
        n_cmp++; if (dout_b !== 32'h0) begin n_bad++; $display("FAIL oor_read_b got %h want 0", dout_b); end
        step(1'b1, 12'd999, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_a !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL word999_kept got %h want CAFEF00D", dout_a); end
        n_cmp++; if (dout_c !== 32'h0) begin n_bad++; $display("FAIL oor_read_c got %h want 0", dout_c); end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (oor_a !== 1'b1) begin n_bad++; $display("FAIL oor_sticky got %b want 1", oor_a); end
        n_cmp++; if (rdc_a !== 32'd2) begin n_bad++; $display("FAIL oor_rd_counted got %0d want 2", rdc_a); end
        step(1'b1, 12'd1001, '0, 4'h0, 1'b1);
        n_cmp++; if (oor_a !== 1'b0) begin n_bad++; $display("FAIL clr_oor got %b want 0", oor_a); end
        n_cmp++; if (rdc_a !== 32'h0 || wrc_a !== 32'h0) begin
            n_bad++; $display("FAIL clr_priority got rd=%h wr=%h want 0/0", rdc_a, wrc_a);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, '0, '0, 4'h0, 1'b1);
        force u_a.rd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_a.rd_cnt_q;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'd0, '0, 4'h0, 1'b0);
            n_cmp++; if (rdc_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL saturate[%0d] got %h want FFFFFFFF", i, rdc_a); end
        end
    endtask

    task automatic test_reset_midop();
        step(1'b1, 12'd3, '0, 4'h0, 1'b0);
        en = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (dout_a !== 32'h0 || dout_b !== 32'h0 || dout_c !== 32'h0) begin
            n_bad++; $display("FAIL midop_reset_dout got %h/%h/%h want 0", dout_a, dout_b, dout_c);
        end
        n_cmp++; if (rdc_a !== 32'h0) begin n_bad++; $display("FAIL midop_reset_cnt got %h want 0", rdc_a); end
        repeat (2) step(1'b0, '0, '0, 4'h0, 1'b0);
        resetn = 1'b1;
        repeat (3) step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'h0) begin n_bad++; $display("FAIL no_stale_c got %h want 0", dout_c); end
        step(1'b1, 12'd3, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_a !== 32'd3) begin n_bad++; $display("FAIL retained_a got %h want 3", dout_a); end
        step(1'b0, '0, '0, 4'h0, 1'b0);
        n_cmp++; if (dout_c !== 32'd3) begin n_bad++; $display("FAIL retained_c got %h want 3", dout_c); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) step(1'b1, AW'(i), $urandom, 4'hF, 1'b0);
        for (int i = 996; i < 1000; i++) step(1'b1, AW'(i), $urandom, 4'hF, 1'b0);
        step(1'b0, '0, '0, 4'h0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) a = AW'(996 + $urandom_range(0, 7));
            else                           a = AW'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, a, $urandom,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                 $urandom_range(0, 19) == 0);
            n_cmp++; if (dout_a !== e_a) begin n_bad++; $display("FAIL rnd_dout_a[%0d] got %h want %h", n, dout_a, e_a); end
            n_cmp++; if (dout_b !== e_b) begin n_bad++; $display("FAIL rnd_dout_b[%0d] got %h want %h", n, dout_b, e_b); end
            n_cmp++; if (dout_c !== e_c) begin n_bad++; $display("FAIL rnd_dout_c[%0d] got %h want %h", n, dout_c, e_c); end
            n_cmp++; if (rdc_a !== m_rd || rdc_b !== m_rd || rdc_c !== m_rd) begin
                n_bad++; $display("FAIL rnd_rd_count[%0d] got %0d/%0d/%0d want %0d", n, rdc_a, rdc_b, rdc_c, m_rd);
            end
            n_cmp++; if (wrc_a !== m_wr || wrc_b !== m_wr || wrc_c !== m_wr) begin
                n_bad++; $display("FAIL rnd_wr_count[%0d] got %0d/%0d/%0d want %0d", n, wrc_a, wrc_b, wrc_c, m_wr);
            end
            n_cmp++; if (oor_a !== m_oor || oor_b !== m_oor || oor_c !== m_oor) begin
                n_bad++; $display("FAIL rnd_oor[%0d] got %b/%b/%b want %b", n, oor_a, oor_b, oor_c, m_oor);
            end
        end
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 4096; i++) m_mem[i] = '0;
        en = 1'b0; cnt_clr = 1'b0; addr = '0; din = '0; we = 4'h0;
        test_reset();
        test_byte_strobes();
        test_write_modes();
        test_latency2_stream();
        test_out_of_range();
        test_saturation();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
